// File: rtl/c64_clk_rst_ctrl.sv
// Clock/reset bring-up for the C64 core: PLL lock qualification, reset hold,
// phi0/phi2 bus-cycle enables and a pause handshake for OSD/loader masters.
//
// state     | meaning
// WAIT_LOCK | core in reset, divider stopped, waiting for synchronised lock
// STABLE    | counting consecutive locked cycles, lock glitch restarts
// HOLD      | divider running, reset held for RESET_HOLD bus cycles
// RUN       | core out of reset, bus cycles may be paused at a cycle boundary
module c64_clk_rst_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_STABLE = 1024,
    parameter int RESET_HOLD  = 256,
    parameter int DIV         = 32,
    parameter int CNT_W       = 16,
    localparam int CW         = $clog2(DIV)
) (
    input  logic          clk32,
    input  logic          reset,
    input  logic          pll_locked,
    input  logic          pause_req,
    input  logic          clr_sticky,
    output logic          sys_reset,
    output logic          phi2_ce,
    output logic          phi0,
    output logic [CW-1:0] cycle_idx,
    output logic          pause_ack,
    output logic          lock_lost,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 lk;
    logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc;
    logic [CW-1:0]        idx_n, idx_wrap;
    logic                 paused_n;
    logic                 set_lost;
    logic                 active_n;

    assign lk       = sync_q[SYNC_STAGES-1];
    assign cnt_inc  = cnt + 1'b1;
    assign idx_wrap = (cycle_idx == CW'(DIV - 1)) ? '0 : cycle_idx + 1'b1;
    assign state_o  = state;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = cycle_idx;
        paused_n = pause_ack;
        set_lost = 1'b0;
        case (state)
            WAIT_LOCK: begin
                idx_n = '0;
                if (lk) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            HOLD: begin
                if (!lk) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    idx_n = idx_wrap;
                    if (phi2_ce) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_W'(RESET_HOLD))
                            state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (!lk) begin
                    state_n  = WAIT_LOCK;
                    cnt_n    = '0;
                    idx_n    = '0;
                    paused_n = 1'b0;
                    set_lost = 1'b1;
                end else if (pause_ack) begin
                    // frozen at idx 0; release restarts a full bus cycle
                    idx_n = '0;
                    if (!pause_req)
                        paused_n = 1'b0;
                end else begin
                    idx_n = idx_wrap;
                    if (phi2_ce && pause_req)
                        paused_n = 1'b1;
                end
            end
            default: state_n = WAIT_LOCK;
        endcase
    end

    assign active_n = (state_n == HOLD) || (state_n == RUN);

    // outputs are registered from next-state values so they line up with cycle_idx
    always_ff @(posedge clk32) begin
        if (reset) begin
            state     <= WAIT_LOCK;
            sync_q    <= '0;
            cnt       <= '0;
            cycle_idx <= '0;
            pause_ack <= 1'b0;
            sys_reset <= 1'b1;
            phi2_ce   <= 1'b0;
            phi0      <= 1'b0;
        end else begin
            state     <= state_n;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            cnt       <= cnt_n;
            cycle_idx <= idx_n;
            pause_ack <= paused_n;
            sys_reset <= (state_n != RUN);
            phi2_ce   <= active_n && !paused_n && (idx_n == CW'(DIV - 1));
            phi0      <= active_n && !paused_n && (idx_n >= CW'(DIV / 2));
        end
    end

    // sticky flag survives master reset; a clear beats a same-cycle set
    always_ff @(posedge clk32) begin
        if (clr_sticky)
            lock_lost <= 1'b0;
        else if (set_lost && !reset)
            lock_lost <= 1'b1;
    end

endmodule

// File: tb/tb_c64_clk_rst_ctrl.sv
// Directed bench for c64_clk_rst_ctrl with short timing parameters
// (LOCK_STABLE=8, RESET_HOLD=4, DIV=4).
module tb_c64_clk_rst_ctrl;

    logic       clk32 = 1'b0;
    logic       reset, pll_locked, pause_req, clr_sticky;
    logic       sys_reset, phi2_ce, phi0, pause_ack, lock_lost;
    logic [1:0] cycle_idx;
    logic [1:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;

    c64_clk_rst_ctrl #(
        .SYNC_STAGES(2), .LOCK_STABLE(8), .RESET_HOLD(4), .DIV(4), .CNT_W(16)
    ) dut (
        .clk32(clk32), .reset(reset), .pll_locked(pll_locked),
        .pause_req(pause_req), .clr_sticky(clr_sticky),
        .sys_reset(sys_reset), .phi2_ce(phi2_ce), .phi0(phi0),
        .cycle_idx(cycle_idx), .pause_ack(pause_ack),
        .lock_lost(lock_lost), .state_o(state_o)
    );

    always #5 clk32 = ~clk32;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk32);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] target, input int max, output int n);
        n = 0;
        while (state_o != target && n < max) begin
            tick();
            n++;
        end
    endtask

    int n, seen;

    initial begin
        reset = 1'b1; pll_locked = 1'b0; pause_req = 1'b0; clr_sticky = 1'b1;
        tick(3);
        clr_sticky = 1'b0;
        tick();
        chk("rst_state", state_o, 0);
        chk("rst_sysrst", sys_reset, 1);
        chk("rst_phi2", phi2_ce, 0);
        chk("rst_phi0", phi0, 0);
        chk("rst_idx", cycle_idx, 0);
        chk("rst_ack", pause_ack, 0);
        chk("rst_lost", lock_lost, 0);

        // bring-up: two sync stages, then STABLE on the next edge
        reset = 1'b0; pll_locked = 1'b1;
        wait_state(2'd1, 20, n);
        chk("stable_lat", n, 3);
        wait_state(2'd2, 20, n);
        chk("hold_lat", n, 8);
        for (int i = 0; i < 16; i++) begin
            chk("hold_idx", cycle_idx, i % 4);
            chk("hold_phi2", phi2_ce, (i % 4) == 3);
            chk("hold_phi0", phi0, (i % 4) >= 2);
            chk("hold_sysrst", sys_reset, 1);
            tick();
        end
        chk("run_state", state_o, 3);
        chk("run_sysrst", sys_reset, 0);
        chk("run_idx0", cycle_idx, 0);

        // pause requested at idx 1: current bus cycle completes first
        tick();
        chk("pre_pause_idx", cycle_idx, 1);
        pause_req = 1'b1;
        tick(2);
        chk("pause_last_phi2", phi2_ce, 1);
        tick();
        chk("pause_ack_on", pause_ack, 1);
        chk("pause_idx", cycle_idx, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (phi2_ce || phi0 || !pause_ack) seen++;
            tick();
        end
        chk("paused_quiet", seen, 0);
        pause_req = 1'b0;
        tick();
        chk("release_ack", pause_ack, 0);
        chk("release_idx", cycle_idx, 0);
        n = 1;
        while (!phi2_ce && n < 10) begin
            tick();
            n++;
        end
        chk("release_phi2_lat", n, 4);

        // lock loss from RUN
        pll_locked = 1'b0;
        tick(2);
        chk("loss_still_run", state_o, 3);
        tick();
        chk("loss_state", state_o, 0);
        chk("loss_sysrst", sys_reset, 1);
        chk("loss_lost", lock_lost, 1);
        chk("loss_idx", cycle_idx, 0);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clr_lost", lock_lost, 0);

        // re-lock with a one-cycle glitch seen by lk at STABLE count 5
        pll_locked = 1'b1;
        wait_state(2'd1, 20, n);
        chk("relock_stable_lat", n, 3);
        tick(3);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        chk("glitch_in_stable", state_o, 1);
        tick();
        chk("glitch_wait", state_o, 0);
        chk("glitch_sysrst", sys_reset, 1);
        tick();
        chk("glitch_restable", state_o, 1);
        tick(7);
        chk("glitch_full_count", state_o, 1);
        tick();
        chk("glitch_hold", state_o, 2);
        tick(15);
        chk("hold_sysrst_late", sys_reset, 1);
        tick();
        chk("relock_run", state_o, 3);
        chk("relock_sysrst", sys_reset, 0);

        // reset while paused in RUN
        wait_state(2'd3, 1, n);
        n = 0;
        while (!phi2_ce && n < 10) begin
            tick();
            n++;
        end
        pause_req = 1'b1;
        tick();
        chk("pause2_ack", pause_ack, 1);
        reset = 1'b1;
        tick();
        chk("rstp_sysrst", sys_reset, 1);
        chk("rstp_ack", pause_ack, 0);
        chk("rstp_idx", cycle_idx, 0);
        chk("rstp_state", state_o, 0);
        chk("rstp_lost", lock_lost, 0);
        reset = 1'b0; pause_req = 1'b0;

        // simultaneous clear and lock loss: clear wins
        wait_state(2'd3, 60, n);
        chk("bringup3_run", state_o, 3);
        pll_locked = 1'b0;
        tick(2);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clrwin_state", state_o, 0);
        chk("clrwin_lost", lock_lost, 0);

        // lock_lost survives master reset
        pll_locked = 1'b1;
        wait_state(2'd3, 60, n);
        chk("bringup4_run", state_o, 3);
        pll_locked = 1'b0;
        tick(3);
        chk("loss2_lost", lock_lost, 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("sticky_thru_rst", lock_lost, 1);
        chk("sticky_rst_state", state_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
